// File: rtl/psum_wb_pkg.sv
// Shared definitions for the partial-sum writeback block: FSM states and
// saturation limits for a signed accumulator of a given width.
package psum_wb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } wb_state_t;

  function automatic logic signed [63:0] sat_max(input int width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int width);
    return -(64'sd1 <<< (width - 1));
  endfunction

endpackage

// File: rtl/psum_writeback_sat_add.sv
// Signed saturating adder: the sum is formed one bit wider, then clamped to
// the representable range of ACCUM_WIDTH; ovf flags any clamp.
module sat_add
  import psum_wb_pkg::*;
#(
  parameter int ACCUM_WIDTH = 32
) (
  input  logic [ACCUM_WIDTH-1:0] a,
  input  logic [ACCUM_WIDTH-1:0] b,
  output logic [ACCUM_WIDTH-1:0] sum,
  output logic                   ovf
);

  localparam logic signed [ACCUM_WIDTH:0] HI = (ACCUM_WIDTH + 1)'(sat_max(ACCUM_WIDTH));
  localparam logic signed [ACCUM_WIDTH:0] LO = (ACCUM_WIDTH + 1)'(sat_min(ACCUM_WIDTH));

  logic signed [ACCUM_WIDTH:0] wide;

  always_comb begin
    wide = $signed({a[ACCUM_WIDTH-1], a}) + $signed({b[ACCUM_WIDTH-1], b});
    sum  = wide[ACCUM_WIDTH-1:0];
    ovf  = 1'b0;
    if (wide > HI) begin
      sum = HI[ACCUM_WIDTH-1:0];
      ovf = 1'b1;
    end else if (wide < LO) begin
      sum = LO[ACCUM_WIDTH-1:0];
      ovf = 1'b1;
    end
  end

endmodule

// File: rtl/psum_writeback.sv
// Collects skewed per-column partial sums of one output tile, accumulates them
// across K tiles with saturation, and streams the finished tile row-major to C.
module psum_writeback
  import psum_wb_pkg::*;
#(
  parameter int ARRAY_SIZE  = 4,
  parameter int ACCUM_WIDTH = 32,
  parameter int ADDR_WIDTH  = 10
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             tile_start,
  input  logic                             first_k,
  input  logic                             last_k,
  input  logic [ADDR_WIDTH-1:0]            base_addr,
  input  logic [7:0]                       row_stride,
  input  logic [ARRAY_SIZE-1:0]            psum_valid,
  input  logic [ARRAY_SIZE*ACCUM_WIDTH-1:0] psum_in,
  output logic                             mem_write_en_c,
  input  logic                             mem_ready_c,
  output logic [ADDR_WIDTH-1:0]            mem_addr_c,
  output logic [ACCUM_WIDTH-1:0]           mem_data_c,
  output logic                             busy,
  output logic                             done,
  output logic                             overflow
);

  localparam int RCW = $clog2(ARRAY_SIZE + 1);
  localparam int IW  = $clog2(ARRAY_SIZE);
  localparam logic [RCW-1:0] RC_FULL  = RCW'(ARRAY_SIZE);
  localparam logic [RCW-1:0] RC_LAST  = RCW'(ARRAY_SIZE - 1);
  localparam logic [IW-1:0]  IDX_LAST = IW'(ARRAY_SIZE - 1);

  // Write handshake: an element transfers on any rising edge where
  // mem_write_en_c && mem_ready_c; while ready is low, address and data hold.
  wb_state_t state, state_nxt;

  logic                   first_k_q, last_k_q;
  logic [ADDR_WIDTH-1:0]  base_q;
  logic [7:0]             stride_q;
  logic [RCW-1:0]         rc [ARRAY_SIZE];
  logic [ACCUM_WIDTH-1:0] tile_buf [ARRAY_SIZE][ARRAY_SIZE];
  logic [IW-1:0]          wr_row, wr_col;
  logic [ARRAY_SIZE-1:0]  cap, col_full_nxt, col_ovf;
  logic [ACCUM_WIDTH-1:0] cap_data [ARRAY_SIZE];

  for (genvar j = 0; j < ARRAY_SIZE; j++) begin : g_col
    logic [ACCUM_WIDTH-1:0] psum_col, sum_col;
    logic                   ovf_col;
    logic [IW-1:0]          row_sel;

    assign psum_col = psum_in[j*ACCUM_WIDTH +: ACCUM_WIDTH];
    assign row_sel  = rc[j][IW-1:0];
    assign cap[j]   = (state == COLLECT) && psum_valid[j] && (rc[j] != RC_FULL);

    sat_add #(.ACCUM_WIDTH(ACCUM_WIDTH)) u_sat_add (
      .a   (tile_buf[row_sel][j]),
      .b   (psum_col),
      .sum (sum_col),
      .ovf (ovf_col)
    );

    assign cap_data[j]     = first_k_q ? psum_col : sum_col;
    assign col_ovf[j]      = cap[j] && !first_k_q && ovf_col;
    assign col_full_nxt[j] = (rc[j] == RC_FULL) || (cap[j] && (rc[j] == RC_LAST));
  end

  // Buffer contents are don't-care after reset, so no reset term here.
  always_ff @(posedge clk) begin
    for (int j = 0; j < ARRAY_SIZE; j++) begin
      if (cap[j]) tile_buf[rc[j][IW-1:0]][j] <= cap_data[j];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      first_k_q <= 1'b0;
      last_k_q  <= 1'b0;
      base_q    <= '0;
      stride_q  <= '0;
      wr_row    <= '0;
      wr_col    <= '0;
      overflow  <= 1'b0;
      for (int j = 0; j < ARRAY_SIZE; j++) rc[j] <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && tile_start) begin
        first_k_q <= first_k;
        last_k_q  <= last_k;
        base_q    <= base_addr;
        stride_q  <= row_stride;
        wr_row    <= '0;
        wr_col    <= '0;
        for (int j = 0; j < ARRAY_SIZE; j++) rc[j] <= '0;
        if (first_k) overflow <= 1'b0;
      end
      for (int j = 0; j < ARRAY_SIZE; j++) begin
        if (cap[j]) rc[j] <= rc[j] + 1'b1;
      end
      if (|col_ovf) overflow <= 1'b1;
      if (state == WRITE && mem_ready_c) begin
        if (wr_col == IDX_LAST) begin
          wr_col <= '0;
          wr_row <= wr_row + 1'b1;
        end else begin
          wr_col <= wr_col + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    mem_write_en_c = 1'b0;
    mem_addr_c     = '0;
    mem_data_c     = '0;
    busy           = (state != IDLE);
    done           = 1'b0;
    case (state)
      IDLE: begin
        if (tile_start) state_nxt = COLLECT;
      end
      COLLECT: begin
        if (&col_full_nxt) state_nxt = last_k_q ? WRITE : DONE;
      end
      WRITE: begin
        mem_write_en_c = 1'b1;
        mem_addr_c     = base_q + ADDR_WIDTH'(wr_row) * ADDR_WIDTH'(stride_q)
                         + ADDR_WIDTH'(wr_col);
        mem_data_c     = tile_buf[wr_row][wr_col];
        if (mem_ready_c && wr_row == IDX_LAST && wr_col == IDX_LAST) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_psum_writeback.sv
// Directed bench for psum_writeback: a matrix-level accumulate model produces
// the expected write stream, checked every cycle, plus literal spot values.
module tb_psum_writeback;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 10;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            tile_start, first_k, last_k;
  logic [DW-1:0]   base_addr;
  logic [7:0]      row_stride;
  logic [N-1:0]    psum_valid;
  logic [N*AW-1:0] psum_in;
  logic            mem_write_en_c, mem_ready_c;
  logic [DW-1:0]   mem_addr_c;
  logic [AW-1:0]   mem_data_c;
  logic            busy, done, overflow;

  psum_writeback #(.ARRAY_SIZE(N), .ACCUM_WIDTH(AW), .ADDR_WIDTH(DW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .tile_start     (tile_start),
    .first_k        (first_k),
    .last_k         (last_k),
    .base_addr      (base_addr),
    .row_stride     (row_stride),
    .psum_valid     (psum_valid),
    .psum_in        (psum_in),
    .mem_write_en_c (mem_write_en_c),
    .mem_ready_c    (mem_ready_c),
    .mem_addr_c     (mem_addr_c),
    .mem_data_c     (mem_data_c),
    .busy           (busy),
    .done           (done),
    .overflow       (overflow)
  );

  // model and scoreboard state
  logic [AW-1:0]      tile_vals [N][N];
  longint             mdl_buf [N][N];
  logic               mdl_ovf;
  logic [DW+AW-1:0]   exp_q[$];
  logic [DW+AW-1:0]   exp_e;
  logic [DW-1:0]      acc_addr [N*N];
  logic [AW-1:0]      acc_data [N*N];
  int acc_idx, first_en_cyc, last_acc_cyc, done_cyc, done_cnt, last_beat_cyc, stall_cnt;
  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  bit bp_en, prev_done, hold_pend;
  logic [DW-1:0] held_addr;
  logic [AW-1:0] held_data;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // memory ready: high except for a 3-cycle stall on element (1,2) when enabled
  always @(posedge clk) begin
    #1;
    if (bp_en && acc_idx == 6 && stall_cnt < 3) begin
      mem_ready_c = 1'b0;
      stall_cnt++;
    end else begin
      mem_ready_c = 1'b1;
    end
  end

  // per-cycle compare against the expected write stream
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_write_en", mem_write_en_c, 0);
      hold_pend = 0;
      prev_done = 0;
    end else begin
      if (prev_done) begin
        check("post_done_busy", busy, 0);
        check("post_done_pulse", done, 0);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_done = done;
      if (hold_pend) begin
        check("hold_en", mem_write_en_c, 1);
        check("hold_addr", mem_addr_c, held_addr);
        check("hold_data", mem_data_c, held_data);
        hold_pend = 0;
      end
      if (mem_write_en_c) begin
        if (first_en_cyc < 0) first_en_cyc = cyc;
        if (mem_ready_c) begin
          if (exp_q.size() == 0) begin
            check("unexpected_write", 1, 0);
          end else begin
            exp_e = exp_q.pop_front();
            check("wr_addr", mem_addr_c, exp_e[DW+AW-1:AW]);
            check("wr_data", mem_data_c, exp_e[AW-1:0]);
          end
          if (acc_idx < N*N) begin
            acc_addr[acc_idx] = mem_addr_c;
            acc_data[acc_idx] = mem_data_c;
          end
          acc_idx++;
          last_acc_cyc = cyc;
        end else begin
          hold_pend = 1;
          held_addr = mem_addr_c;
          held_data = mem_data_c;
        end
      end
    end
  end

  task automatic set_vals(input int kind, input logic [AW-1:0] k);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        case (kind)
          0: tile_vals[r][c] = k;
          1: tile_vals[r][c] = AW'(100 * r + c);
          2: tile_vals[r][c] = AW'(r + 1);
          default: tile_vals[r][c] = k + AW'(10 * r + c);
        endcase
  endtask

  // driver: model update, tile_start pulse, skewed column beats, completion checks
  task automatic run_tile(input logic fk, input logic lk, input logic [DW-1:0] base,
                          input logic [7:0] stride, input int skew, input int extra,
                          input bit bp, input int abort_at);
    int total, start_cnt, row, n;
    longint s;
    logic ovf_before;
    ovf_before = mdl_ovf;
    if (fk) mdl_ovf = 0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        if (fk) begin
          mdl_buf[r][c] = longint'($signed(tile_vals[r][c]));
        end else begin
          s = mdl_buf[r][c] + longint'($signed(tile_vals[r][c]));
          if (s > SMAX) begin s = SMAX; mdl_ovf = 1; end
          if (s < SMIN) begin s = SMIN; mdl_ovf = 1; end
          mdl_buf[r][c] = s;
        end
      end
    if (lk)
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          exp_q.push_back({DW'(int'(base) + r * int'(stride) + c), AW'(mdl_buf[r][c])});
    acc_idx = 0; first_en_cyc = -1; stall_cnt = 0; bp_en = bp; start_cnt = done_cnt;

    @(posedge clk); #1;
    tile_start = 1; first_k = fk; last_k = lk; base_addr = base; row_stride = stride;
    @(posedge clk); #1;
    tile_start = 0; first_k = 0; last_k = 0;
    check("ovf_at_start", overflow, fk ? 1'b0 : ovf_before);

    total = N + extra + (N - 1) * skew;
    for (int t = 0; t < total; t++) begin
      for (int j = 0; j < N; j++) begin
        row = t - j * skew;
        psum_valid[j] = (row >= 0 && row < N + extra);
        psum_in[j*AW +: AW] = (row >= 0 && row < N) ? tile_vals[row][j] : (32'hDEAD0000 + AW'(row));
      end
      if (t == (N - 1) + (N - 1) * skew) last_beat_cyc = cyc;
      @(posedge clk); #1;
    end
    psum_valid = '0;
    psum_in = '0;

    if (abort_at >= 0) begin
      n = 0;
      while (acc_idx < abort_at && n < 300) begin @(negedge clk); #1; n++; end
      check("abort_reached", acc_idx, abort_at);
      rst_n = 0;
      #1;
      check("rst_now_en", mem_write_en_c, 0);
      check("rst_now_busy", busy, 0);
      check("rst_now_done", done, 0);
      check("rst_now_ovf", overflow, 0);
      exp_q.delete();
      mdl_ovf = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      return;
    end

    n = 0;
    while (done_cnt == start_cnt && n < 300) begin @(negedge clk); #1; n++; end
    check("done_seen", done_cnt - start_cnt, 1);
    if (lk) begin
      check("write_count", acc_idx, N * N);
      check("first_write_lat", first_en_cyc, last_beat_cyc + 1);
      check("done_after_last", done_cyc, last_acc_cyc + 1);
    end else begin
      check("no_writes", acc_idx, 0);
      check("done_latency", done_cyc, last_beat_cyc + 1);
    end
    check("exp_q_empty", exp_q.size(), 0);
    check("overflow", overflow, mdl_ovf);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    tile_start = 0; first_k = 0; last_k = 0; base_addr = '0; row_stride = '0;
    psum_valid = '0; psum_in = '0; mem_ready_c = 1; mdl_ovf = 0;
    bp_en = 0; done_cnt = 0; acc_idx = 0; stall_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_en", mem_write_en_c, 0);
    check("reset_ovf", overflow, 0);
    check("reset_addr", mem_addr_c, 0);
    check("reset_data", mem_data_c, 0);
    rst_n = 1;

    // basic single-K tile
    set_vals(1, 0);
    run_tile(1, 1, 10'h010, 8'd8, 0, 0, 0, -1);
    check("lit_addr0", acc_addr[0], 10'h010);
    check("lit_addr4", acc_addr[4], 10'h018);
    check("lit_addr15", acc_addr[15], 10'h02B);
    check("lit_data6", acc_data[6], 32'd102);
    check("lit_data15", acc_data[15], 32'd303);

    // column skew
    set_vals(2, 0);
    run_tile(1, 1, 10'h100, 8'd4, 1, 0, 0, -1);
    check("lit_skew_data12", acc_data[12], 32'd4);

    // two K tiles
    set_vals(0, 32'd1);
    run_tile(1, 0, 10'h040, 8'd4, 0, 0, 0, -1);
    set_vals(0, 32'd2);
    run_tile(0, 1, 10'h040, 8'd4, 0, 0, 0, -1);
    check("lit_2k_data0", acc_data[0], 32'd3);
    check("lit_2k_data15", acc_data[15], 32'd3);

    // positive saturation, sticky overflow, then clear on first_k
    set_vals(0, 32'h7FFFFFF0);
    run_tile(1, 0, 10'h000, 8'd4, 0, 0, 0, -1);
    set_vals(0, 32'h00000020);
    run_tile(0, 1, 10'h000, 8'd4, 0, 0, 0, -1);
    check("lit_sat_data5", acc_data[5], 32'h7FFFFFFF);
    check("lit_sat_ovf", overflow, 1);
    set_vals(0, 32'hFFFFFFFB);
    run_tile(0, 1, 10'h000, 8'd4, 0, 0, 0, -1);
    check("lit_sticky_data", acc_data[0], 32'h7FFFFFFA);
    check("lit_sticky_ovf", overflow, 1);

    // negative saturation
    set_vals(0, 32'h80000005);
    run_tile(1, 0, 10'h000, 8'd4, 0, 0, 0, -1);
    check("lit_ovf_cleared", overflow, 0);
    set_vals(0, 32'hFFFFFFF6);
    run_tile(0, 1, 10'h000, 8'd4, 0, 0, 0, -1);
    check("lit_negsat_data", acc_data[0], 32'h80000000);

    // backpressure on element (1,2) with address wrap
    set_vals(3, 32'd1000);
    run_tile(1, 1, 10'h3F8, 8'h20, 0, 0, 1, -1);
    check("lit_bp_data6", acc_data[6], 32'd1012);
    check("lit_bp_addr15", acc_addr[15], 10'h05B);

    // reset during writeback, then clean restart with surplus beats
    set_vals(0, 32'd5);
    run_tile(1, 1, 10'h200, 8'd4, 0, 0, 0, 7);
    set_vals(3, 32'd50);
    run_tile(1, 1, 10'h080, 8'd4, 1, 2, 0, -1);
    check("lit_restart_data0", acc_data[0], 32'd50);
    check("lit_restart_data15", acc_data[15], 32'd83);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/psum_writeback.md
Name: psum_writeback

Overview:
- Downstream of the systolic array controller and PE array.
- Captures skewed per-column partial-sum outputs of one ARRAY_SIZE x ARRAY_SIZE output tile into an internal tile buffer.
- Accumulates across K tiles with saturating signed add.
- After the last K tile, streams the finished tile to result memory C, row-major, under a valid/ready write handshake.

Parameters:
- ARRAY_SIZE, 4, tile edge; number of columns and rows per tile.
- ACCUM_WIDTH, 32, signed partial-sum and result width.
- ADDR_WIDTH, 10, result memory address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- tile_start  in  1  one-cycle pulse that begins collection of a tile; honoured only in IDLE
- first_k  in  1  sampled with tile_start; 1 = overwrite buffer, 0 = accumulate into buffer
- last_k  in  1  sampled with tile_start; 1 = write the tile to memory after collection
- base_addr  in  ADDR_WIDTH  sampled with tile_start; address of tile element (0,0)
- row_stride  in  8  sampled with tile_start; address step between tile rows (matrix N)
- psum_valid  in  ARRAY_SIZE  per-column valid; bit j qualifies column j of psum_in
- psum_in  in  ARRAY_SIZE*ACCUM_WIDTH  column j occupies bits [j*ACCUM_WIDTH +: ACCUM_WIDTH], signed
- mem_write_en_c  out  1  write request valid
- mem_ready_c  in  1  memory accepts the write this cycle
- mem_addr_c  out  ADDR_WIDTH  write address
- mem_data_c  out  ACCUM_WIDTH  write data
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse at the end of each tile, write or no write
- overflow  out  1  sticky saturation flag

Behaviour:
- Reset values: all outputs 0; state IDLE; column counters 0; buffer contents undefined.
- Reset mid-operation aborts immediately, with no partial memory writes after reset.

States:
- IDLE -> COLLECT on tile_start. Latch first_k, last_k, base_addr, row_stride. Clear column counters. Clear overflow when first_k=1.
- COLLECT:
  - Each column j keeps a row counter rc[j], 0..ARRAY_SIZE.
  - When psum_valid[j]=1 and rc[j]<ARRAY_SIZE, write buf[rc[j]][j] and increment rc[j].
  - The written value is psum_in[j] if first_k, else sat(buf[rc[j]][j] + psum_in[j]).
  - Valid beats on a column with rc[j]==ARRAY_SIZE are ignored.
  - Columns are independent, so arbitrary skew between columns is legal and simultaneous valids on all columns are legal.
  - Completion is when every rc[j]==ARRAY_SIZE, counting captures made this cycle. Next state is WRITE if last_k, else DONE.
- WRITE:
  - Index (r,c) starts at (0,0).
  - mem_write_en_c=1, mem_addr_c = base_addr + r*row_stride + c (mod 2^ADDR_WIDTH wrap), mem_data_c = buf[r][c].
  - Address and data are held stable while mem_ready_c=0.
  - On en&&ready, advance c; at c==ARRAY_SIZE-1, wrap c to 0 and increment r.
  - The first write is presented in the cycle after completion.
  - After element (ARRAY_SIZE-1, ARRAY_SIZE-1) is accepted: next state DONE, mem_write_en_c drops the same edge.
- DONE: done=1 for exactly one cycle -> IDLE.
- tile_start outside IDLE is ignored. psum_valid in IDLE, WRITE or DONE is ignored.

Arithmetic:
- Signed add computed at ACCUM_WIDTH+1 bits.
- Result clamps to +2^(ACCUM_WIDTH-1)-1 or -2^(ACCUM_WIDTH-1).
- Any clamp sets overflow, which holds until the next first_k tile_start.

Throughput:
- Collection takes at least ARRAY_SIZE cycles.
- Writeback takes ARRAY_SIZE^2 cycles when mem_ready_c is held high.

Decomposition:
- Shared package psum_wb_pkg: state enum {IDLE, COLLECT, WRITE, DONE} and the saturation limit constants derived from ACCUM_WIDTH.
- One sub-module: sat_add (combinational, parameter ACCUM_WIDTH; inputs a, b; outputs sum, ovf), instantiated once per column.

Test Plan:
- ARRAY_SIZE=4, first_k=1, last_k=1, base 0x010, stride 8; all columns valid 4 cycles, value 100*r+c; ready high -> 16 writes at 0x010..0x013, 0x018.., 0x028..0x02B with data 100*r+c; done pulses one cycle after the last write; busy low the cycle after that.
- Skew: column j valid starts j cycles after column 0, values r+1 -> WRITE begins the cycle after column 3 row 3 is captured; all data correct.
- Two K tiles: tile A first_k=1, last_k=0, all ones -> no writes, done pulse. Tile B first_k=0, last_k=1, all 2s -> 16 writes of value 3.
- Saturation: tile A 0x7FFFFFF0, tile B +0x20 -> data 0x7FFFFFFF, overflow=1; stays 1 through a following first_k=0 tile and clears on the next first_k=1 tile_start.
- Backpressure: mem_ready_c low for 3 cycles on element (1,2) -> address and data held constant; no skipped or duplicated element; 16 accepted writes total.
- Reset: assert rst_n=0 at write 7 -> mem_write_en_c, busy, done, overflow are 0 immediately; tile_start after release restarts a clean collection; extra valid beats beyond 4 per column are ignored.
